seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Observes a multiplexed common-anode 7-segment display bus (active-low segments
//  and anodes) and reconstructs the BCD digit shown on each position. Receive-side
//  counterpart of the BCD-to-7-segment encoder. Used for display loopback checking
//  and for reading digits from external display-driving boards.
// PARAMETERS
//  NUM_DIGITS  4  number of multiplexed digit positions (anode lines)
//  STABLE_CNT  3  consecutive identical qualified samples needed to confirm a digit (>=1)
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             synchronous, active-high reset
//  sample_en    in   1             sampling strobe; state advances only when high
//  seg_in       in   7             segments, active-low, [6]=a ... [0]=g, asynchronous
//  an_in        in   NUM_DIGITS    anodes, active-low, [i]=digit i, asynchronous
//  bcd_out      out  4*NUM_DIGITS  confirmed digit i on [4i+3:4i]
//  digit_valid  out  NUM_DIGITS    digit i confirmed at least once since reset
//  pattern_err  out  NUM_DIGITS    last confirmed pattern for digit i is not 0-9
//  digit_upd    out  1             1-cycle pulse when any digit is (re)confirmed
//  frame_done   out  1             1-cycle pulse when every digit has confirmed since last pulse
// BEHAVIOUR
//  - One clock, clk; rst is synchronous and active-high. On rst: all outputs 0, all
//    counters, pattern registers and frame mask cleared. Reset mid-count discards
//    partial progress; no pulse is issued.
//  - seg_in/an_in pass through a 2-FF synchroniser (always running, cleared by rst
//    to all-ones = blank/off).
//  - Qualified sample: sample_en=1 and synchronised an has exactly one bit 0. Zero or
//    multiple low anodes = blanking/ghosting: sample ignored, counters untouched.
//  - Tracking: registers cur_dig (index) and cur_pat (7b), match counter cnt.
//    Qualified sample with same index and pattern: cnt++ (saturates at STABLE_CNT).
//    Different index or pattern: cur_dig/cur_pat load, cnt=1.
//  - Confirm fires on the sample where cnt reaches STABLE_CNT (once per run; staying
//    saturated does not refire). Next cycle: bcd_out[cur_dig], digit_valid, pattern_err
//    update, digit_upd=1, frame-mask bit set.
//  - Decode table (pattern -> BCD): 0000001->0, 1001111->1, 0010010->2, 0000110->3,
//    1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
//    Any other pattern (incl. blank 1111111): bcd=4'hF, pattern_err=1.
//  - frame_done: asserted the cycle after the confirm that completes the frame mask;
//    mask clears in the same cycle. Confirms of an already-set digit do not advance.
//    Confirm completing the mask while it clears: that digit's bit stays set.
//  - Latency: input change -> bcd_out = 2 sync cycles + STABLE_CNT qualified samples + 1.
//  - sample_en=0: all tracking state held; outputs held; pulses 0.
//  - STABLE_CNT=1: every qualified sample whose index/pattern differs from the last
//    confirms.
// STRUCTURE
//  - seg7_pkg: SEG_0..SEG_9 and SEG_BLANK constants (active-low, a..g), BCD_INVALID=4'hF.
//    Encoder and this block both take patterns from it.
//  - Sub-module seg7_to_bcd: combinational lookup, pattern[6:0] -> bcd[3:0] + err.
//  - Top: synchroniser, one-hot check/encode of an, tracking counter, per-digit
//    output registers, frame mask.
// TESTING (NUM_DIGITS=4, STABLE_CNT=3, sample_en=1 unless stated)
//  1 Scan 0,1,2,3 with an=1110,1101,1011,0111, seg=SEG_d, 4 samples each ->
//    bcd_out=16'h3210, digit_valid=1111, four digit_upd pulses, one frame_done.
//  2 an=1110 seg=SEG_7 for exactly 2 samples, then an=1101 -> no digit 0 update
//    (cnt never reaches 3).
//  3 an=1011 seg=7'b1111111 for 3 samples -> bcd_out[11:8]=F, pattern_err[2]=1,
//    digit_valid[2]=1.
//  4 an=1100 (two low) or 1111 between valid samples of digit 1 -> ignored;
//    run continues, confirms at the 3rd valid sample.
//  5 Mid-run: toggle sample_en 1,0,0,1,1 with a steady digit -> confirms on the 3rd
//    enabled sample; nothing changes while disabled.
//  6 After test 1, assert rst one cycle mid-count -> all outputs 0 next cycle;
//    rescan gives a fresh frame_done.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the scan decoder.
// Patterns are active-low, bit order [6]=a ... [0]=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational reverse lookup of an active-low 7-segment pattern.
// Ports:
//   pat_i  [6:0]  segment pattern, active-low, [6]=a ... [0]=g
//   bcd_o  [3:0]  decoded digit, BCD_INVALID when not a 0-9 glyph
//   err_o         high when the pattern is not a 0-9 glyph (blank included)
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = BCD_INVALID;
    err_o = 1'b1;
    case (pat_i)
      SEG_0: begin bcd_o = 4'd0; err_o = 1'b0; end
      SEG_1: begin bcd_o = 4'd1; err_o = 1'b0; end
      SEG_2: begin bcd_o = 4'd2; err_o = 1'b0; end
      SEG_3: begin bcd_o = 4'd3; err_o = 1'b0; end
      SEG_4: begin bcd_o = 4'd4; err_o = 1'b0; end
      SEG_5: begin bcd_o = 4'd5; err_o = 1'b0; end
      SEG_6: begin bcd_o = 4'd6; err_o = 1'b0; end
      SEG_7: begin bcd_o = 4'd7; err_o = 1'b0; end
      SEG_8: begin bcd_o = 4'd8; err_o = 1'b0; end
      SEG_9: begin bcd_o = 4'd9; err_o = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed common-anode 7-segment bus and recovers the BCD digit
// shown on each position once its pattern has been seen STABLE_CNT times in a row.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   sample_en    sampling strobe; tracking only advances when high
//   seg_in [6:0] segments, active-low, asynchronous
//   an_in        anodes, active-low, one per digit, asynchronous
//   bcd_out      confirmed digit i on [4i+3:4i]
//   digit_valid  digit i confirmed at least once since reset
//   pattern_err  last confirmed pattern of digit i was not 0-9
//   digit_upd    one-cycle pulse on each (re)confirm
//   frame_done   one-cycle pulse once every digit has confirmed since the last pulse
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    digit_upd,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  // Synchroniser; idles at all-ones so reset looks like a blanked display.
  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

  logic [IDX_W-1:0] cur_dig_q, cur_dig_d;
  logic [6:0]       cur_pat_q, cur_pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             confirm_d, confirm_q;

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_set;
  logic                    upd_q, upd_d, frame_q, frame_d;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  one_hot, qual, same;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            dec_bcd;
  logic                  dec_err;

  // Exactly one anode low; none or several means blanking or ghosting.
  always_comb begin
    an_low  = ~an_s2_q;
    one_hot = (an_low != '0) && ((an_low & (an_low - AN_ONE)) == '0);
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) idx = IDX_W'(i);
    end
    qual = sample_en && one_hot;
    same = (idx == cur_dig_q) && (seg_s2_q == cur_pat_q);
  end

  // Run tracking: confirm only on the sample that brings the run to STABLE_CNT.
  always_comb begin
    cur_dig_d = cur_dig_q;
    cur_pat_d = cur_pat_q;
    cnt_d     = cnt_q;
    confirm_d = 1'b0;
    if (qual) begin
      if (same) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d     = cnt_q + CNT_ONE;
          confirm_d = (cnt_q == CNT_PRE);
        end
      end else begin
        cur_dig_d = idx;
        cur_pat_d = seg_s2_q;
        cnt_d     = CNT_ONE;
        confirm_d = (STABLE_CNT == 1);
      end
    end
  end

  // cur_pat_q still holds the confirmed pattern during the cycle after confirm.
  seg7_to_bcd u_dec (
    .pat_i (cur_pat_q),
    .bcd_o (dec_bcd),
    .err_o (dec_err)
  );

  always_comb begin
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    err_d    = err_q;
    mask_d   = mask_q;
    mask_set = mask_q;
    upd_d    = 1'b0;
    frame_d  = 1'b0;
    if (confirm_q) begin
      upd_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cur_dig_q == IDX_W'(i)) begin
          bcd_d[4*i +: 4] = dec_bcd;
          valid_d[i]      = 1'b1;
          err_d[i]        = dec_err;
          mask_set[i]     = 1'b1;
        end
      end
      if (&mask_set) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_set;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q  <= SEG_BLANK;
      seg_s2_q  <= SEG_BLANK;
      an_s1_q   <= '1;
      an_s2_q   <= '1;
      cur_dig_q <= '0;
      cur_pat_q <= '0;
      cnt_q     <= '0;
      confirm_q <= 1'b0;
      bcd_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      mask_q    <= '0;
      upd_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      seg_s1_q  <= seg_in;
      seg_s2_q  <= seg_s1_q;
      an_s1_q   <= an_in;
      an_s2_q   <= an_s1_q;
      cur_dig_q <= cur_dig_d;
      cur_pat_q <= cur_pat_d;
      cnt_q     <= cnt_d;
      confirm_q <= confirm_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      upd_q     <= upd_d;
      frame_q   <= frame_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign pattern_err = err_q;
  assign digit_upd   = upd_q;
  assign frame_done  = frame_q;

endmodule
